control_fsm: RTL

CONTROL_FSM -- requirements
Module: control_fsm

---
 rtl/control_fsm.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/control_fsm.sv
// Multi-cycle processor control unit: Moore FSM sequencing fetch, decode,
// execute, memory and write-back, plus a retired-instruction counter.
module control_fsm #(
    parameter logic [5:0] OP_NOP  = 6'b000000,
    parameter logic [5:0] OP_LW   = 6'b100000,
    parameter logic [5:0] OP_SW   = 6'b100001,
    parameter logic [5:0] OP_LLI  = 6'b100010,
    parameter logic [5:0] OP_LUI  = 6'b100011,
    parameter logic [5:0] OP_BEQ  = 6'b110000,
    parameter logic [5:0] OP_J    = 6'b110010,
    parameter logic [5:0] OP_HALT = 6'b111111
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic        zero,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        IRWrite,
    output logic        DMEMWrite,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic        RegReadSel,
    output logic [1:0]  MemtoReg,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  PCSource,
    output logic [3:0]  ALUSel,
    output logic [3:0]  state,
    output logic        halted,
    output logic        illegal_op,
    output logic [15:0] retired
);

    localparam int unsigned RET_W = 16;
    localparam logic [3:0]  ALU_ADD = 4'b0000;
    localparam logic [3:0]  ALU_SUB = 4'b0001;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_EXEC_I = 4'd3,
        S_WB_ALU = 4'd4,
        S_MEM_RD = 4'd5,
        S_WB_MEM = 4'd6,
        S_MEM_WR = 4'd7,
        S_WB_IMM = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_HALT   = 4'd11
    } state_t;

    state_t             state_q;
    state_t             dec_next;
    logic               dec_illegal;
    logic               retire;
    logic [RET_W-1:0]   retired_q;

    // The branch outcome is resolved in the datapath via PCWriteCond.
    logic unused_zero;
    assign unused_zero = zero;

    // Opcode decode: target state out of DECODE and undefined-opcode flag.
    always_comb begin
        dec_next    = S_FETCH;
        dec_illegal = 1'b0;
        if (opcode == OP_LW)                                dec_next = S_MEM_RD;
        else if (opcode == OP_SW)                           dec_next = S_MEM_WR;
        else if (opcode == OP_LLI || opcode == OP_LUI)      dec_next = S_WB_IMM;
        else if (opcode == OP_BEQ)                          dec_next = S_BRANCH;
        else if (opcode == OP_J)                            dec_next = S_JUMP;
        else if (opcode == OP_HALT)                         dec_next = S_HALT;
        else if (opcode == OP_NOP)                          dec_next = S_FETCH;
        else if (opcode[5:4] == 2'b00 && opcode[3:0] != 4'd0) dec_next = S_EXEC_R;
        else if (opcode[5:4] == 2'b01)                      dec_next = S_EXEC_I;
        else                                                dec_illegal = 1'b1;
    end

    // An instruction completes on the edge leaving its final state.
    always_comb begin
        retire = 1'b0;
        case (state_q)
            S_WB_ALU, S_WB_MEM, S_MEM_WR, S_WB_IMM, S_BRANCH, S_JUMP: retire = 1'b1;
            S_DECODE: retire = (opcode == OP_NOP);
            default:  retire = 1'b0;
        endcase
    end

    // State sequencing and retired-instruction counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            if (retire) retired_q <= retired_q + RET_W'(1);
            case (state_q)
                S_FETCH:          state_q <= S_DECODE;
                S_DECODE:         state_q <= dec_next;
                S_EXEC_R,
                S_EXEC_I:         state_q <= S_WB_ALU;
                S_MEM_RD:         state_q <= S_WB_MEM;
                S_HALT:           state_q <= S_HALT;
                default:          state_q <= S_FETCH;
            endcase
        end
    end

    // Moore output decode, forced low while reset is held.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IRWrite     = 1'b0;
        DMEMWrite   = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        RegReadSel  = 1'b0;
        MemtoReg    = 2'b00;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        ALUSel      = ALU_ADD;
        halted      = 1'b0;
        illegal_op  = 1'b0;
        if (reset) begin
            RegReadSel = (opcode == OP_SW) || (opcode == OP_LLI) ||
                         (opcode == OP_LUI) || (opcode == OP_BEQ);
            case (state_q)
                S_FETCH: begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    ALUSrcB = 2'b01;
                end
                S_DECODE: begin
                    ALUSrcB    = 2'b10;
                    illegal_op = dec_illegal;
                end
                S_EXEC_R: begin
                    ALUSrcA = 1'b1;
                    ALUSel  = opcode[3:0];
                end
                S_EXEC_I: begin
                    ALUSrcA = 1'b1;
                    ALUSel  = opcode[3:0];
                    ALUSrcB = opcode[3] ? 2'b11 : 2'b10;
                end
                S_WB_ALU: RegWrite = 1'b1;
                S_WB_MEM: begin
                    RegWrite = 1'b1;
                    MemtoReg = 2'b01;
                end
                S_MEM_WR: DMEMWrite = 1'b1;
                S_WB_IMM: begin
                    RegWrite = 1'b1;
                    MemtoReg = (opcode == OP_LUI) ? 2'b11 : 2'b10;
                end
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUSel      = ALU_SUB;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                end
                S_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule
